// File: rtl/rv32_instr_encoder_if.sv
// Encoder bus: decoded-field input channel, encoded-word output channel and error status.
interface rv32_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic        err_clr;

  // Program generator / boot loader side.
  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready, err_clr,
    input  in_ready, out_valid, out_instr, out_addr, err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready, err_clr,
    output in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words, range-checks the
// immediate, and queues each legal word with its byte address in a small FIFO.
module rv32_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input logic                 clk,
  input logic                 reset,
  rv32_instr_encoder_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  localparam logic [3:0] ClsLui   = 4'd0;
  localparam logic [3:0] ClsAuipc = 4'd1;
  localparam logic [3:0] ClsJal   = 4'd2;
  localparam logic [3:0] ClsJalr  = 4'd3;
  localparam logic [3:0] ClsBr    = 4'd4;
  localparam logic [3:0] ClsLoad  = 4'd5;
  localparam logic [3:0] ClsStore = 4'd6;
  localparam logic [3:0] ClsAluI  = 4'd7;
  localparam logic [3:0] ClsAluR  = 4'd8;

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAluI  = 7'b0010011;
  localparam logic [6:0] OpAluR  = 7'b0110011;

  logic [31:0] imm;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        alt;
  logic        i_ok, b_ok, j_ok, is_shift;

  logic [31:0] enc_word;
  logic        enc_err;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     addr_q, addr_d;
  logic            err_q, err_d;
  logic            accept, push, pop;

  assign imm = bus.in_imm;
  assign f3  = bus.in_funct3;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign alt = bus.in_alt;

  // Sign-extension checks: every bit above the encodable field must match the sign bit.
  assign i_ok     = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok     = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok     = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Combinational field packing and legality check for the presented fields.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (bus.in_class)
      ClsLui: begin
        enc_word = {imm[31:12], rd, OpLui};
        enc_err  = |imm[11:0];
      end
      ClsAuipc: begin
        enc_word = {imm[31:12], rd, OpAuipc};
        enc_err  = |imm[11:0];
      end
      ClsJal: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
        enc_err  = ~j_ok;
      end
      ClsJalr: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OpJalr};
        enc_err  = ~i_ok;
      end
      ClsBr: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpBr};
        enc_err  = ~b_ok || (f3 == 3'b010) || (f3 == 3'b011);
      end
      ClsLoad: begin
        enc_word = {imm[11:0], rs1, f3, rd, OpLoad};
        enc_err  = ~i_ok;
      end
      ClsStore: begin
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OpStore};
        enc_err  = ~i_ok;
      end
      ClsAluI: begin
        if (is_shift) begin
          // Shifts carry SRAI/SRLI select in bit 30 and a 5-bit shamt.
          enc_word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OpAluI};
          enc_err  = |imm[31:5];
        end else begin
          enc_word = {imm[11:0], rs1, f3, rd, OpAluI};
          enc_err  = ~i_ok;
        end
      end
      ClsAluR: begin
        enc_word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OpAluR};
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  assign bus.in_ready  = (count_q < FullCnt);
  assign bus.out_valid = (count_q != '0);
  assign bus.err       = err_q;

  // An illegal word still completes the handshake but is never queued.
  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & ~enc_err;
  assign pop    = bus.out_valid & bus.out_ready;

  // Outputs read as zero while the FIFO is empty so reset leaves them at zero.
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr_q]  : '0;

  // Next-state for FIFO pointers, occupancy, address counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      addr_d   = addr_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A new error wins over a same-cycle clear.
    if (accept && enc_err) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are don't-care until marked valid by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q]  <= addr_q;
    end
  end

endmodule
